// File: rtl/fetch_target_queue.sv
// fetch_target_queue: circular FIFO of predicted fetch blocks between BPU, IFU and backend commit
module fetch_target_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int PTR_WIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bpu_valid_i,
  input  logic [ADDR_WIDTH-1:0] bpu_start_pc_i,
  input  logic [2:0]            bpu_length_i,
  input  logic                  bpu_is_cross_cacheline_i,
  input  logic                  bpu_predicted_taken_i,
  output logic                  ftq_full_o,
  output logic                  ifu_valid_o,
  input  logic                  ifu_ready_i,
  output logic [ADDR_WIDTH-1:0] ifu_start_pc_o,
  output logic [2:0]            ifu_length_o,
  output logic                  ifu_is_cross_cacheline_o,
  output logic [PTR_WIDTH-2:0]  ifu_ftq_id_o,
  input  logic                  commit_valid_i,
  input  logic                  commit_is_conditional_i,
  input  logic                  commit_taken_i,
  input  logic                  flush_i,
  output logic                  meta_valid_o,
  output logic [ADDR_WIDTH-1:0] meta_start_pc_o,
  output logic                  meta_is_conditional_o,
  output logic                  meta_is_taken_o
);
  localparam int IW = PTR_WIDTH - 1;
  logic [PTR_WIDTH-1:0]  bpu_ptr, ifu_ptr, comm_ptr, count, comm_nxt;
  logic [ADDR_WIDTH-1:0] pc_q [DEPTH];
  logic [2:0]            len_q [DEPTH];
  logic                  xcl_q [DEPTH];
  logic                  enq, iss, com, unused_pred_taken;
  // predicted direction is not consumed by this queue's consumers
  assign unused_pred_taken = bpu_predicted_taken_i;
  assign count        = bpu_ptr - comm_ptr;
  assign ftq_full_o   = count == PTR_WIDTH'(DEPTH);
  assign ifu_valid_o  = ifu_ptr != bpu_ptr;
  assign enq          = bpu_valid_i & ~ftq_full_o & ~flush_i;
  assign iss          = ifu_valid_o & ifu_ready_i & ~flush_i;
  assign com          = commit_valid_i & (comm_ptr != ifu_ptr);
  assign comm_nxt     = comm_ptr + PTR_WIDTH'(com);
  assign ifu_ftq_id_o             = ifu_ptr[IW-1:0];
  assign ifu_start_pc_o           = pc_q[ifu_ptr[IW-1:0]];
  assign ifu_length_o             = len_q[ifu_ptr[IW-1:0]];
  assign ifu_is_cross_cacheline_o = xcl_q[ifu_ptr[IW-1:0]];
  always_ff @(posedge clk)
    if (enq) begin
      pc_q[bpu_ptr[IW-1:0]]  <= bpu_start_pc_i;
      len_q[bpu_ptr[IW-1:0]] <= bpu_length_i;
      xcl_q[bpu_ptr[IW-1:0]] <= bpu_is_cross_cacheline_i;
    end
  // a flush collapses all pointers onto the post-commit retire pointer
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bpu_ptr               <= '0;
      ifu_ptr               <= '0;
      comm_ptr              <= '0;
      meta_valid_o          <= 1'b0;
      meta_start_pc_o       <= '0;
      meta_is_conditional_o <= 1'b0;
      meta_is_taken_o       <= 1'b0;
    end else begin
      comm_ptr     <= comm_nxt;
      bpu_ptr      <= flush_i ? comm_nxt : bpu_ptr + PTR_WIDTH'(enq);
      ifu_ptr      <= flush_i ? comm_nxt : ifu_ptr + PTR_WIDTH'(iss);
      meta_valid_o <= com;
      if (com) begin
        meta_start_pc_o       <= pc_q[comm_ptr[IW-1:0]];
        meta_is_conditional_o <= commit_is_conditional_i;
        meta_is_taken_o       <= commit_taken_i;
      end
    end
endmodule

// File: tb/tb_fetch_target_queue.sv
// tb_fetch_target_queue: table vectors, directed corner sequences and random stimulus vs a queue model
module tb_fetch_target_queue;
  localparam int DEPTH = 8;
  localparam logic [31:0] BASE = 32'h1c00_0000;
  logic clk = 0, rst = 0;
  logic bv = 0, xcl = 0, pt = 0, rdy = 0, cv = 0, cond = 0, tk = 0, fl = 0;
  logic [31:0] pc = 0;
  logic [2:0] len = 1;
  logic full, iv, ixcl, mv, mc, mt;
  logic [31:0] ipc, mpc;
  logic [2:0] ilen;
  logic [2:0] iid;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;

  fetch_target_queue #(.ADDR_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .bpu_valid_i(bv), .bpu_start_pc_i(pc), .bpu_length_i(len),
    .bpu_is_cross_cacheline_i(xcl), .bpu_predicted_taken_i(pt),
    .ftq_full_o(full), .ifu_valid_o(iv), .ifu_ready_i(rdy),
    .ifu_start_pc_o(ipc), .ifu_length_o(ilen), .ifu_is_cross_cacheline_o(ixcl),
    .ifu_ftq_id_o(iid),
    .commit_valid_i(cv), .commit_is_conditional_i(cond), .commit_taken_i(tk),
    .flush_i(fl),
    .meta_valid_o(mv), .meta_start_pc_o(mpc),
    .meta_is_conditional_o(mc), .meta_is_taken_o(mt)
  );

  typedef struct {logic [31:0] pc; logic [2:0] len; logic x;} ent_t;
  ent_t q[$];
  int issued = 0, head_id = 0;
  logic m_v = 0, m_c = 0, m_t = 0;
  logic [31:0] m_pc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete(); issued = 0; head_id = 0; m_v = 0; m_c = 0; m_t = 0; m_pc = 0;
  endtask

  task automatic model_step();
    bit fm, cm, im, em;
    fm = q.size() == DEPTH;
    cm = cv && issued > 0;
    im = issued < q.size() && rdy && !fl;
    em = bv && !fm && !fl;
    m_v = cm;
    if (cm) begin
      m_pc = q[0].pc; m_c = cond; m_t = tk;
      void'(q.pop_front());
      issued--;
      head_id = (head_id + 1) % DEPTH;
    end
    if (fl) begin
      q.delete(); issued = 0;
    end else begin
      if (im) issued++;
      if (em) q.push_back('{pc, len, xcl});
    end
  endtask

  task automatic model_check();
    chk("full", full, q.size() == DEPTH);
    chk("ifu_valid", iv, issued < q.size());
    if (issued < q.size()) begin
      chk("ifu_pc", ipc, q[issued].pc);
      chk("ifu_len", ilen, q[issued].len);
      chk("ifu_xcl", ixcl, q[issued].x);
      chk("ifu_id", iid, (head_id + issued) % DEPTH);
    end
    chk("meta_valid", mv, m_v);
    chk("meta_pc", mpc, m_pc);
    chk("meta_cond", mc, m_c);
    chk("meta_taken", mt, m_t);
  endtask

  task automatic step(input logic b, input logic [31:0] p, input logic [2:0] l, input logic r,
                      input logic c, input logic cd, input logic t, input logic f);
    bv = b; pc = p; len = l; xcl = p[4]; pt = p[5]; rdy = r; cv = c; cond = cd; tk = t; fl = f;
    @(posedge clk);
    model_step();
    #1;
    model_check();
  endtask

  task automatic do_reset();
    bv = 0; rdy = 0; cv = 0; fl = 0;
    rst = 1;
    model_reset();
    #1;
    chk("rst_full", full, 0);
    chk("rst_valid", iv, 0);
    chk("rst_meta", mv, 0);
    @(posedge clk);
    #1 rst = 0;
  endtask

  typedef struct {
    logic b; logic [31:0] p; logic [2:0] l; logic r, c, cd, t;
    logic e_full, e_iv; logic [31:0] e_ipc; logic e_mv; logic [31:0] e_mpc; logic e_mt;
  } vec_t;
  vec_t tbl[7];

  function automatic vec_t mk(logic b, logic [31:0] p, logic [2:0] l, logic r, logic c, logic cd,
                              logic t, logic ef, logic ei, logic [31:0] eip, logic em,
                              logic [31:0] emp, logic emt);
    vec_t v;
    v = '{b, p, l, r, c, cd, t, ef, ei, eip, em, emp, emt};
    return v;
  endfunction

  initial begin
    int metas, issues;
    tbl[0] = mk(1, BASE + 32'h40, 4, 0, 0, 0, 0, 0, 1, BASE + 32'h40, 0, 0, 0);
    tbl[1] = mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2] = mk(0, 0, 1, 0, 1, 1, 1, 0, 0, 0, 1, BASE + 32'h40, 1);
    tbl[3] = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4] = mk(1, BASE + 32'h80, 2, 0, 1, 0, 0, 0, 1, BASE + 32'h80, 0, 0, 0);
    tbl[5] = mk(1, BASE + 32'hc0, 3, 1, 0, 0, 0, 0, 1, BASE + 32'hc0, 0, 0, 0);
    tbl[6] = mk(0, 0, 1, 0, 1, 0, 0, 0, 1, BASE + 32'hc0, 1, BASE + 32'h80, 0);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].b, tbl[i].p, tbl[i].l, tbl[i].r, tbl[i].c, tbl[i].cd, tbl[i].t, 0);
      chk($sformatf("tbl%0d_full", i), full, tbl[i].e_full);
      chk($sformatf("tbl%0d_iv", i), iv, tbl[i].e_iv);
      if (tbl[i].e_iv) chk($sformatf("tbl%0d_ipc", i), ipc, tbl[i].e_ipc);
      chk($sformatf("tbl%0d_mv", i), mv, tbl[i].e_mv);
      if (tbl[i].e_mv) begin
        chk($sformatf("tbl%0d_mpc", i), mpc, tbl[i].e_mpc);
        chk($sformatf("tbl%0d_mt", i), mt, tbl[i].e_mt);
      end
    end
    // async reset in the middle of a cycle with traffic in flight
    for (int k = 0; k < 3; k++) step(1, BASE + 32'h100 + 16 * k, 2, k[0], 0, 0, 0, 0);
    #3 rst = 1;
    model_reset();
    #1;
    chk("midrst_full", full, 0);
    chk("midrst_valid", iv, 0);
    chk("midrst_meta", mv, 0);
    @(posedge clk);
    #1 rst = 0;
    chk("postrst_valid", iv, 0);
    chk("postrst_meta", mv, 0);
    step(1, BASE + 32'h200, 1, 0, 0, 0, 0, 0);
    chk("postrst_id", iid, 0);
    chk("postrst_pc", ipc, BASE + 32'h200);
    // fill to full, ninth enqueue dropped
    do_reset();
    for (int k = 0; k < 9; k++) begin
      step(1, BASE + 16 * k, 1, 0, 0, 0, 0, 0);
      if (k == 6) chk("fill7_full", full, 0);
      if (k >= 7) chk($sformatf("fill%0d_full", k + 1), full, 1);
    end
    chk("first_issue_pc", ipc, BASE);
    issues = 0;
    for (int k = 0; k < 10; k++) begin
      if (iv) issues++;
      step(0, 0, 1, 1, 0, 0, 0, 0);
    end
    chk("drained_issues", issues, 8);
    chk("drained_valid", iv, 0);
    // flush together with a legal commit
    do_reset();
    for (int k = 0; k < 5; k++) step(1, BASE + 16 * k, 3, 0, 0, 0, 0, 0);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 1, 0, 0, 0, 0);
    step(1, BASE + 32'h900, 1, 1, 1, 0, 1, 1);
    chk("flush_meta_v", mv, 1);
    chk("flush_meta_pc", mpc, BASE);
    chk("flush_valid", iv, 0);
    chk("flush_full", full, 0);
    step(1, BASE + 32'h500, 2, 0, 0, 0, 0, 0);
    chk("flush_next_id", iid, 1);
    chk("flush_next_pc", ipc, BASE + 32'h500);
    // steady stream wrapping the pointers twice
    do_reset();
    metas = 0;
    for (int k = 0; k < 22; k++) begin
      step(k < 20, BASE + 16 * k, 4, 1, 1, k[0], k[1], 0);
      chk("wrap_full", full, 0);
      if (mv) begin
        chk("wrap_meta_pc", mpc, BASE + 16 * metas);
        metas++;
      end
    end
    chk("wrap_meta_count", metas, 20);
    // random traffic against the model
    do_reset();
    for (int k = 0; k < 800; k++)
      step($urandom_range(0, 3) != 0, $urandom & 32'hffff_fffc, 3'($urandom_range(1, 4)),
           $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, $urandom_range(0, 24) == 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
